// File: rtl/umi_mem_agent_pkg.sv
// UMI opcode and atomic-subtype constants shared by the memory agent.
// Opcodes live in cmd[3:0]; atomic subtypes live in cmd[15:8].
package umi_mem_agent_pkg;

  localparam logic [3:0] UMI_REQ_READ   = 4'h1;
  localparam logic [3:0] UMI_RESP_READ  = 4'h2;
  localparam logic [3:0] UMI_REQ_WRITE  = 4'h3;
  localparam logic [3:0] UMI_RESP_WRITE = 4'h4;
  localparam logic [3:0] UMI_REQ_POSTED = 4'h5;
  localparam logic [3:0] UMI_REQ_ATOMIC = 4'h9;

  localparam logic [7:0] UMI_ATOMIC_ADD  = 8'h00;
  localparam logic [7:0] UMI_ATOMIC_AND  = 8'h01;
  localparam logic [7:0] UMI_ATOMIC_OR   = 8'h02;
  localparam logic [7:0] UMI_ATOMIC_XOR  = 8'h03;
  localparam logic [7:0] UMI_ATOMIC_MAX  = 8'h04;
  localparam logic [7:0] UMI_ATOMIC_MIN  = 8'h05;
  localparam logic [7:0] UMI_ATOMIC_MAXU = 8'h06;
  localparam logic [7:0] UMI_ATOMIC_MINU = 8'h07;
  localparam logic [7:0] UMI_ATOMIC_SWAP = 8'h08;

endpackage

// File: rtl/umi_mem_agent_decode.sv
// Classifies a UMI command into the request kinds the agent executes.
// Everything else, including responses and unknown atomics, is unsupported.
module umi_mem_agent_decode
  import umi_mem_agent_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic [CW-1:0] cmd,
  output logic          is_read,
  output logic          is_write,
  output logic          is_posted,
  output logic          is_atomic,
  output logic          is_unsup
);

  logic [3:0] op;
  logic [7:0] atype;

  assign op    = cmd[3:0];
  assign atype = cmd[15:8];

  always_comb begin
    is_read   = 1'b0;
    is_write  = 1'b0;
    is_posted = 1'b0;
    is_atomic = 1'b0;
    is_unsup  = 1'b0;
    unique case (1'b1)
      op == UMI_REQ_READ:   is_read   = 1'b1;
      op == UMI_REQ_WRITE:  is_write  = 1'b1;
      op == UMI_REQ_POSTED: is_posted = 1'b1;
      op == UMI_REQ_ATOMIC &&
        atype <= UMI_ATOMIC_SWAP:
                            is_atomic = 1'b1;
      default:              is_unsup  = 1'b1;
    endcase
  end

endmodule

// File: rtl/umi_mem_agent.sv
// Device-side UMI request executor: one transaction at a time,
// read/write/atomic RMW on a single-port local bus, then a UMI response.
module umi_mem_agent
  import umi_mem_agent_pkg::*;
#(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          udev_req_valid,
  input  logic [CW-1:0] udev_req_cmd,
  input  logic [AW-1:0] udev_req_dstaddr,
  input  logic [AW-1:0] udev_req_srcaddr,
  input  logic [DW-1:0] udev_req_data,
  output logic          udev_req_ready,
  output logic          udev_resp_valid,
  output logic [CW-1:0] udev_resp_cmd,
  output logic [AW-1:0] udev_resp_dstaddr,
  output logic [AW-1:0] udev_resp_srcaddr,
  output logic [DW-1:0] udev_resp_data,
  input  logic          udev_resp_ready,
  output logic          loc_req,
  output logic          loc_we,
  output logic [AW-1:0] loc_addr,
  output logic [DW-1:0] loc_wdata,
  input  logic          loc_ready,
  input  logic [DW-1:0] loc_rdata,
  output logic          err_unsupported
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LREQ,
    S_LRD,
    S_AWR,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cmd_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] src_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] old_q;
  logic          err_q;
  logic [DW-1:0] alu_res;
  logic [CW-1:0] dec_cmd;
  logic          accept;
  logic          d_read, d_write, d_posted;
  logic          d_atomic, d_unsup;

  // Decode the live command while idle, the captured one afterwards.
  assign dec_cmd = (state == S_IDLE) ? udev_req_cmd : cmd_q;
  assign accept  = udev_req_valid & udev_req_ready;

  umi_mem_agent_decode #(.CW(CW)) u_decode (
    .cmd       (dec_cmd),
    .is_read   (d_read),
    .is_write  (d_write),
    .is_posted (d_posted),
    .is_atomic (d_atomic),
    .is_unsup  (d_unsup)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (accept && !d_unsup) state_nxt = S_LREQ;
      S_LREQ:
        if (loc_ready) begin
          if (d_write)       state_nxt = S_RESP;
          else if (d_posted) state_nxt = S_IDLE;
          else               state_nxt = S_LRD;
        end
      S_LRD:
        state_nxt = d_atomic ? S_AWR : S_RESP;
      S_AWR:
        if (loc_ready) state_nxt = S_RESP;
      S_RESP:
        if (udev_resp_ready) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    udev_req_ready  = 1'b0;
    udev_resp_valid = 1'b0;
    loc_req         = 1'b0;
    loc_we          = 1'b0;
    case (state)
      S_IDLE: udev_req_ready = nreset;
      S_LREQ: begin
        loc_req = 1'b1;
        loc_we  = d_write | d_posted;
      end
      S_AWR: begin
        loc_req = 1'b1;
        loc_we  = 1'b1;
      end
      S_RESP: udev_resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cmd_q  <= '0;
      dst_q  <= '0;
      src_q  <= '0;
      data_q <= '0;
      old_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept & d_unsup;
      if (accept) begin
        cmd_q  <= udev_req_cmd;
        dst_q  <= udev_req_dstaddr;
        src_q  <= udev_req_srcaddr;
        data_q <= udev_req_data;
      end
      if (state == S_LRD) old_q <= loc_rdata;
    end
  end

  always_comb begin
    alu_res = data_q;
    case (cmd_q[15:8])
      UMI_ATOMIC_ADD:  alu_res = old_q + data_q;
      UMI_ATOMIC_AND:  alu_res = old_q & data_q;
      UMI_ATOMIC_OR:   alu_res = old_q | data_q;
      UMI_ATOMIC_XOR:  alu_res = old_q ^ data_q;
      UMI_ATOMIC_MAX:
        alu_res = ($signed(old_q) > $signed(data_q)) ? old_q : data_q;
      UMI_ATOMIC_MIN:
        alu_res = ($signed(old_q) < $signed(data_q)) ? old_q : data_q;
      UMI_ATOMIC_MAXU: alu_res = (old_q > data_q) ? old_q : data_q;
      UMI_ATOMIC_MINU: alu_res = (old_q < data_q) ? old_q : data_q;
      UMI_ATOMIC_SWAP: alu_res = data_q;
      default:         alu_res = data_q;
    endcase
  end

  assign loc_addr  = dst_q;
  assign loc_wdata = (state == S_AWR) ? alu_res : data_q;

  assign udev_resp_cmd = {cmd_q[CW-1:4],
                          d_write ? UMI_RESP_WRITE : UMI_RESP_READ};
  assign udev_resp_dstaddr = src_q;
  assign udev_resp_srcaddr = dst_q;
  assign udev_resp_data    = d_write ? '0 : old_q;
  assign err_unsupported   = err_q;

endmodule

// File: tb/tb_umi_mem_agent.sv
// Randomized bench for umi_mem_agent against a transaction-level
// memory model; the local bus is a behavioural SRAM with random stalls.
module tb_umi_mem_agent;

  localparam logic [3:0] OP_RD  = 4'h1;
  localparam logic [3:0] OP_WR  = 4'h3;
  localparam logic [3:0] OP_PW  = 4'h5;
  localparam logic [3:0] OP_AMO = 4'h9;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        udev_req_valid = 1'b0;
  logic [31:0] udev_req_cmd = '0;
  logic [63:0] udev_req_dstaddr = '0;
  logic [63:0] udev_req_srcaddr = '0;
  logic [63:0] udev_req_data = '0;
  logic        udev_req_ready;
  logic        udev_resp_valid;
  logic [31:0] udev_resp_cmd;
  logic [63:0] udev_resp_dstaddr;
  logic [63:0] udev_resp_srcaddr;
  logic [63:0] udev_resp_data;
  logic        udev_resp_ready = 1'b0;
  logic        loc_req;
  logic        loc_we;
  logic [63:0] loc_addr;
  logic [63:0] loc_wdata;
  logic        loc_ready = 1'b0;
  logic [63:0] loc_rdata = '0;
  logic        err_unsupported;

  always #5 clk = ~clk;

  umi_mem_agent dut (
    .clk               (clk),
    .nreset            (nreset),
    .udev_req_valid    (udev_req_valid),
    .udev_req_cmd      (udev_req_cmd),
    .udev_req_dstaddr  (udev_req_dstaddr),
    .udev_req_srcaddr  (udev_req_srcaddr),
    .udev_req_data     (udev_req_data),
    .udev_req_ready    (udev_req_ready),
    .udev_resp_valid   (udev_resp_valid),
    .udev_resp_cmd     (udev_resp_cmd),
    .udev_resp_dstaddr (udev_resp_dstaddr),
    .udev_resp_srcaddr (udev_resp_srcaddr),
    .udev_resp_data    (udev_resp_data),
    .udev_resp_ready   (udev_resp_ready),
    .loc_req           (loc_req),
    .loc_we            (loc_we),
    .loc_addr          (loc_addr),
    .loc_wdata         (loc_wdata),
    .loc_ready         (loc_ready),
    .loc_rdata         (loc_rdata),
    .err_unsupported   (err_unsupported)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] bus_mem [logic [63:0]];

  int ready_mode = 0;
  int loc_cycles = 0;
  int err_cnt    = 0;

  logic        p_req = 1'b0, p_hs = 1'b0, p_we = 1'b0, p_err = 1'b0;
  logic [63:0] p_addr = '0, p_wd = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] bus_rd(input logic [63:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] amo(input logic [7:0] at,
                                      input logic [63:0] o,
                                      input logic [63:0] d);
    longint so, sd;
    so = longint'(o);
    sd = longint'(d);
    case (at)
      8'd0: return o + d;
      8'd1: return o & d;
      8'd2: return o | d;
      8'd3: return o ^ d;
      8'd4: return (so > sd) ? o : d;
      8'd5: return (so < sd) ? o : d;
      8'd6: return (o > d) ? o : d;
      8'd7: return (o < d) ? o : d;
      default: return d;
    endcase
  endfunction

  // Local bus: hold check, random ready, sample handshake before the edge.
  always @(negedge clk) begin
    if (nreset && p_req && !p_hs) begin
      check("loc_hold_req", {62'b0, loc_req, loc_we}, {62'b0, 1'b1, p_we});
      check("loc_hold_addr", loc_addr, p_addr);
      check("loc_hold_wdata", loc_wdata, p_wd);
    end
    case (ready_mode)
      1:       loc_ready = 1'b0;
      2:       loc_ready = 1'b1;
      3:       loc_ready = !loc_we;
      default: loc_ready = ($urandom_range(0, 2) != 0);
    endcase
    p_req  = loc_req && nreset;
    p_hs   = loc_req && loc_ready && nreset;
    p_we   = loc_we;
    p_addr = loc_addr;
    p_wd   = loc_wdata;
    p_err  = err_unsupported;
  end

  always @(posedge clk) begin
    if (p_req) loc_cycles++;
    if (p_err) err_cnt++;
    if (p_hs && p_we) begin
      bus_mem[p_addr] = p_wd;
      loc_rdata <= {$urandom, $urandom};
    end else if (p_hs) begin
      loc_rdata <= bus_rd(p_addr);
    end else begin
      loc_rdata <= {$urandom, $urandom};
    end
  end

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (udev_req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_resp(input logic [31:0] ecmd,
                           input logic [63:0] edst,
                           input logic [63:0] esrc,
                           input logic [63:0] edata,
                           input int stall);
    bit done = 0;
    int seen = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (udev_resp_valid) begin
        seen++;
        check("resp_cmd", {32'b0, udev_resp_cmd}, {32'b0, ecmd});
        check("resp_dst", udev_resp_dstaddr, edst);
        check("resp_src", udev_resp_srcaddr, esrc);
        check("resp_data", udev_resp_data, edata);
        udev_resp_ready = (seen > stall) && ($urandom_range(0, 1) == 1);
        if (udev_resp_ready) begin
          @(posedge clk);
          @(negedge clk);
          udev_resp_ready = 1'b0;
          done = 1;
          check("resp_drop", {63'b0, udev_resp_valid}, 64'h0);
        end else begin
          @(negedge clk);
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("resp_timeout", 0, 1);
    if (done && seen <= stall) check("resp_stall_len", seen, stall + 1);
  endtask

  task automatic xact(input logic [31:0] cmd,
                      input logic [63:0] dst,
                      input logic [63:0] src,
                      input logic [63:0] data,
                      input int stall);
    logic [3:0]  op;
    logic [7:0]  at;
    logic [63:0] old, edata;
    logic [31:0] ecmd;
    int kind, lc0, ec0;
    bit acc = 0;
    op = cmd[3:0];
    at = cmd[15:8];
    old = ref_rd(dst);
    edata = 64'h0;
    ecmd = 32'h0;
    kind = 2;
    if (op == OP_RD) begin
      kind = 0;
      edata = old;
      ecmd = {cmd[31:4], 4'h2};
    end else if (op == OP_WR) begin
      kind = 0;
      ref_mem[dst] = data;
      ecmd = {cmd[31:4], 4'h4};
    end else if (op == OP_PW) begin
      kind = 1;
      ref_mem[dst] = data;
    end else if (op == OP_AMO && at <= 8'd8) begin
      kind = 0;
      ref_mem[dst] = amo(at, old, data);
      edata = old;
      ecmd = {cmd[31:4], 4'h2};
    end

    @(negedge clk);
    udev_req_valid   = 1'b1;
    udev_req_cmd     = cmd;
    udev_req_dstaddr = dst;
    udev_req_srcaddr = src;
    udev_req_data    = data;
    for (int i = 0; i < 200; i++) begin
      if (udev_req_ready) begin
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) begin
      check("req_accept", 0, 1);
      udev_req_valid = 1'b0;
      return;
    end
    lc0 = loc_cycles;
    ec0 = err_cnt;
    @(posedge clk);
    @(negedge clk);
    udev_req_valid   = 1'b0;
    udev_req_cmd     = $urandom;
    udev_req_dstaddr = {$urandom, $urandom};
    udev_req_srcaddr = {$urandom, $urandom};
    udev_req_data    = {$urandom, $urandom};

    if (kind == 0) begin
      wait_resp(ecmd, src, dst, edata, stall);
    end else if (kind == 1) begin
      wait_idle("posted");
      @(negedge clk);
      check("posted_no_resp", {63'b0, udev_resp_valid}, 64'h0);
    end else begin
      check("err_pulse", {63'b0, err_unsupported}, 64'h1);
      check("unsup_idle", {63'b0, udev_req_ready}, 64'h1);
      @(negedge clk);
      @(negedge clk);
      check("err_width", err_cnt - ec0, 1);
      check("unsup_no_loc", loc_cycles - lc0, 0);
    end
    check("mem", bus_rd(dst), ref_rd(dst));
  endtask

  initial begin
    logic [3:0]  ops [10];
    logic [63:0] addrs [4];
    logic [31:0] c;
    bit ok;
    ops   = '{OP_RD, OP_WR, OP_PW, OP_AMO, OP_AMO,
              4'h0, 4'h7, 4'hB, 4'hF, 4'h2};
    addrs = '{64'h100, 64'h108, 64'h200, 64'h300};

    #2;
    check("rst_req_ready", {63'b0, udev_req_ready}, 64'h0);
    check("rst_resp_valid", {63'b0, udev_resp_valid}, 64'h0);
    check("rst_loc", {62'b0, loc_req, loc_we}, 64'h0);
    check("rst_err", {63'b0, err_unsupported}, 64'h0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("idle_req_ready", {63'b0, udev_req_ready}, 64'h1);

    xact(32'h0000_0003, 64'h100, 64'h9000, 64'hDEAD, 0);
    check("t1_mem", bus_rd(64'h100), 64'hDEAD);
    xact(32'h0000_0001, 64'h100, 64'h9000, 64'h0, 5);

    xact(32'h0000_0003, 64'h100, 64'h9008, '1, 0);
    xact(32'h0000_0009, 64'h100, 64'h9010, 64'h1, 0);
    check("t3_wrap", bus_rd(64'h100), 64'h0);

    xact(32'h0000_0003, 64'h100, 64'h9018, 64'h1, 0);
    xact(32'h0000_0409, 64'h100, 64'h9020, 64'h8000_0000_0000_0000, 0);
    check("t4_max", bus_rd(64'h100), 64'h1);
    xact(32'h0000_0609, 64'h100, 64'h9028, 64'h8000_0000_0000_0000, 0);
    check("t4_maxu", bus_rd(64'h100), 64'h8000_0000_0000_0000);

    xact(32'h0000_0005, 64'h200, 64'h9030, 64'h5, 0);
    check("t5_posted", bus_rd(64'h200), 64'h5);
    xact(32'h0000_0007, 64'h200, 64'h9038, 64'h7, 0);

    // Reset while the atomic write-back is stalled.
    xact(32'h0000_0003, 64'h300, 64'h9040, 64'h55, 0);
    ready_mode = 3;
    @(negedge clk);
    udev_req_valid   = 1'b1;
    udev_req_cmd     = 32'h0000_0009;
    udev_req_dstaddr = 64'h300;
    udev_req_srcaddr = 64'h9048;
    udev_req_data    = 64'h1;
    wait_idle("t6_accept");
    @(posedge clk);
    @(negedge clk);
    udev_req_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (loc_req && loc_we) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("t6_reach_awr", {63'b0, ok}, 64'h1);
    @(negedge clk);
    @(negedge clk);
    #1 nreset = 1'b0;
    #1;
    check("t6_loc_req", {62'b0, loc_req, loc_we}, 64'h0);
    check("t6_resp_valid", {63'b0, udev_resp_valid}, 64'h0);
    check("t6_req_ready", {63'b0, udev_req_ready}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    check("t6_idle", {63'b0, udev_req_ready}, 64'h1);
    check("t6_mem", bus_rd(64'h300), ref_rd(64'h300));

    for (int n = 0; n < 60; n++) begin
      c = $urandom;
      c[3:0] = ops[$urandom_range(0, 9)];
      if (c[3:0] == OP_AMO) c[15:8] = 8'($urandom_range(0, 9));
      xact(c, addrs[$urandom_range(0, 3)], {$urandom, $urandom},
           {$urandom, $urandom}, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", n_tests);
    $fatal(1, "timeout");
  end

endmodule
